// File: rtl/mem_sys_pkg.sv
// Constants and types shared by the memory responder and the cache controller.
// Bank select sits just above the byte-offset bit so consecutive words interleave.
package mem_sys_pkg;
  localparam int NUM_BANKS    = 4;
  localparam int BANK_CYC_DEF = 4;
  localparam int RD_LAT       = 2;
  localparam int WORD_W       = 16;
  localparam int ADDR_W       = 16;
  localparam int BANK_LSB     = 1;
  localparam int BANK_MSB     = 2;
  localparam int BANK_W       = BANK_MSB - BANK_LSB + 1;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [BANK_W-1:0] bank_t;

  function automatic bank_t bank_of(input addr_t a);
    return a[BANK_MSB:BANK_LSB];
  endfunction
endpackage

// File: rtl/mem_bank_timer.sv
// Per-bank occupancy counter: load on accept, count down to zero, busy while nonzero.
// Busy rises the cycle after the load and stays up for BANK_CYC-1 cycles.
module mem_bank_timer #(
  parameter int BANK_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic busy_o
);
  localparam int CNT_W = (BANK_CYC > 2) ? $clog2(BANK_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(BANK_CYC - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/mem_bank_responder.sv
// Four-bank interleaved word memory: one request per cycle, reads return 2 cycles after accept.
// A request to a busy bank stalls; illegal requests raise err and are dropped.
module mem_bank_responder
  import mem_sys_pkg::*;
#(
  parameter int WORD_ADDR_W = 15,
  parameter int BANK_CYC    = BANK_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  addr_t                addr,
  input  word_t                data_in,
  input  logic                 wr,
  input  logic                 rd,
  output word_t                data_out,
  output logic                 data_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);
  bank_t                  bank;
  logic [WORD_ADDR_W-1:0] idx;
  logic                   req, illegal, accept, rd_acc;
  logic [NUM_BANKS-1:0]   load;
  addr_t                  unused_addr;

  // Address bits above the word index are ignored, so the array aliases.
  assign unused_addr = addr;
  assign bank    = bank_of(addr);
  assign idx     = addr[WORD_ADDR_W:1];
  assign req     = rd ^ wr;
  assign illegal = (rd & wr) | ((rd | wr) & addr[0]);
  assign err     = illegal;
  assign stall   = req & ~illegal & busy[bank];
  assign accept  = req & ~illegal & ~busy[bank];
  assign rd_acc  = accept & rd;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign load[b] = accept && (bank == bank_t'(b));
    mem_bank_timer #(.BANK_CYC(BANK_CYC)) u_timer (
      .clk    (clk),
      .rst_n  (rst),
      .load_i (load[b]),
      .busy_o (busy[b])
    );
  end

  // Storage has no reset so its contents survive a reset pulse.
  word_t mem_q [2**WORD_ADDR_W];

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem_q[idx] <= data_in;
    end
  end

  logic [RD_LAT-1:0] vld_q, vld_d;
  word_t             dat_q [RD_LAT];
  word_t             dat_d [RD_LAT];

  // Data is zeroed at entry so every stage reads 0 whenever it is not valid.
  always_comb begin
    vld_d[0] = rd_acc;
    dat_d[0] = rd_acc ? mem_q[idx] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign data_out   = dat_q[RD_LAT-1];
  assign data_valid = vld_q[RD_LAT-1];
endmodule

// File: tb/tb_mem_bank_responder.sv
// Scoreboard bench for mem_bank_responder with a 3-bit word index so aliasing is visible.
module tb_mem_bank_responder;
  localparam int WA = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr, rd;
  logic [15:0] data_out;
  logic        data_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  mem_bank_responder #(.WORD_ADDR_W(WA), .BANK_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data_in    (data_in),
    .wr         (wr),
    .rd         (rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .stall      (stall),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dat;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mmem [8];
  int          mb [4];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          stall_cnt = 0;
  logic        m_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] model_busy();
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = (mb[b] != 0);
    return r;
  endfunction

  // One request cycle: drive just after the edge, check combinational outputs before the next.
  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    logic req, ill, est;
    int   bk;
    rd = r; wr = w; addr = a; data_in = d;
    #3;
    bk    = int'(a[2:1]);
    req   = r ^ w;
    ill   = (r & w) | ((r | w) & a[0]);
    est   = req & ~ill & (mb[bk] != 0);
    m_acc = req & ~ill & (mb[bk] == 0);
    if (est) stall_cnt++;
    check("err", 32'(err), 32'(ill));
    check("stall", 32'(stall), 32'(est));
    check("busy", 32'(busy), 32'(model_busy()));
    if (m_acc && w) mmem[a[3:1]] = d;
    if (m_acc && r) sbq.push_back('{dat: mmem[a[3:1]], due: cyc + 2});
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      if (m_acc && b == bk) mb[b] = 3;
      else if (mb[b] > 0) mb[b]--;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic hold(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                      output int nstall);
    logic done;
    done   = 1'b0;
    nstall = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      drive(r, w, a, d);
      if (m_acc) done = 1'b1;
      else nstall++;
    end
    if (!done) check("hold_timeout", 32'(0), 32'(1));
  endtask

  // Read-return scoreboard: a return is due exactly at its recorded cycle, otherwise outputs idle at 0.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      check("dvld", 32'(data_valid), 32'(1));
      check("dout", 32'(data_out), 32'(sbq[0].dat));
      void'(sbq.pop_front());
    end else begin
      check("dvld_idle", 32'(data_valid), 32'(0));
      check("dout_idle", 32'(data_out), 32'(0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, s0;
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    for (int b = 0; b < 4; b++) mb[b] = 0;
    for (int i = 0; i < 8; i++) mmem[i] = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_dvld", 32'(data_valid), 32'(0));
    check("rst_dout", 32'(data_out), 32'(0));
    rst = 1'b1;

    // Write then read after the bank frees: no stall, returns 0xBEEF.
    drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    idle(3);
    s0 = stall_cnt;
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    check("wr_rd_nostall", 32'(stall_cnt - s0), 32'(0));
    idle(3);

    // Same-bank conflict: held read stalls for three cycles.
    drive(1'b0, 1'b1, 16'h0020, 16'hAAAA);
    idle(3);
    drive(1'b0, 1'b1, 16'h0028, 16'h5555);
    idle(3);
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    hold(1'b1, 1'b0, 16'h0028, 16'h0000, n);
    check("conflict_stalls", 32'(n), 32'(3));
    idle(3);

    // Interleave across four banks back to back.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 16'h0040 + 16'(2 * i), 16'(i + 1));
    s0 = stall_cnt;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h0040 + 16'(2 * i), 16'h0000);
    check("interleave_stalls", 32'(stall_cnt - s0), 32'(0));
    idle(3);

    // Illegal requests, then a legal read accepted at once.
    drive(1'b1, 1'b1, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 16'h0003, 16'h0000);
    s0 = stall_cnt;
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    check("post_illegal_nostall", 32'(stall_cnt - s0), 32'(0));
    idle(3);

    // Reset one cycle after a read accept drops the read and frees the bank.
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    rst = 1'b0;
    sbq.delete();
    for (int b = 0; b < 4; b++) mb[b] = 0;
    idle(2);
    rst = 1'b1;
    s0 = stall_cnt;
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    check("post_rst_nostall", 32'(stall_cnt - s0), 32'(0));
    idle(3);

    // Index aliasing: 0x0012 and 0x0002 share a word with a 3-bit index.
    drive(1'b0, 1'b1, 16'h0002, 16'h1234);
    idle(3);
    drive(1'b0, 1'b1, 16'h0012, 16'h5678);
    idle(3);
    drive(1'b1, 1'b0, 16'h0002, 16'h0000);
    idle(4);

    check("sb_empty", 32'(sbq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
